// File: rtl/vanilla_remote_load_wb.sv
// Buffers remote load responses and presents them as writebacks
// to the integer or FP register file write ports, in arrival order.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   resp_v_i, resp_i        incoming response {float_wb, reg_id,
//                           is_unsigned_op, is_byte_op, is_hex_op,
//                           part_sel[1:0], data[31:0]}
//   resp_ready_o            buffer has room (independent of dequeue)
//   int_wb_v_o/_reg_id_o/_data_o, int_wb_yumi_i
//                           integer RF writeback, aligned and extended
//   float_wb_v_o/_reg_id_o/_data_o, float_wb_yumi_i
//                           FP RF writeback, raw word
//   count_o, empty_o        occupancy
module vanilla_remote_load_wb #(
    parameter int els_p          = 2,
    parameter int reg_id_width_p = 5,
    parameter int data_width_p   = 32,
    localparam int ptr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp  = $clog2(els_p + 1),
    localparam int resp_width_lp = reg_id_width_p + 6 + data_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      resp_v_i,
    input  logic [resp_width_lp-1:0]  resp_i,
    output logic                      resp_ready_o,

    output logic                      int_wb_v_o,
    output logic [reg_id_width_p-1:0] int_wb_reg_id_o,
    output logic [data_width_p-1:0]   int_wb_data_o,
    input  logic                      int_wb_yumi_i,

    output logic                      float_wb_v_o,
    output logic [reg_id_width_p-1:0] float_wb_reg_id_o,
    output logic [data_width_p-1:0]   float_wb_data_o,
    input  logic                      float_wb_yumi_i,

    output logic [cnt_width_lp-1:0]   count_o,
    output logic                      empty_o
);

    typedef struct packed {
        logic                      float_wb;
        logic [reg_id_width_p-1:0] reg_id;
        logic                      is_unsigned_op;
        logic                      is_byte_op;
        logic                      is_hex_op;
        logic [1:0]                part_sel;
        logic [data_width_p-1:0]   data;
    } resp_s;

    resp_s                   mem_q [els_p];
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;

    resp_s head;
    logic  empty;
    logic  enq;
    logic  deq;

    assign empty        = (count_q == '0);
    assign resp_ready_o = (count_q != cnt_width_lp'(els_p));
    assign enq          = resp_v_i & resp_ready_o;
    assign head         = mem_q[rd_ptr_q];

    assign int_wb_v_o   = ~empty & ~head.float_wb;
    assign float_wb_v_o = ~empty &  head.float_wb;

    // A yumi on the port that is not presenting is ignored.
    assign deq = (int_wb_v_o   & int_wb_yumi_i)
               | (float_wb_v_o & float_wb_yumi_i);

    // Pointer / count next state. els_p is a power of two, so the
    // pointers wrap naturally at their width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (enq & ~reset_i) begin
            mem_q[wr_ptr_q] <= resp_s'(resp_i);
        end
    end

    // Integer load alignment and extension.
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [data_width_p-1:0] int_data;
    logic                    sext;

    always_comb begin
        byte_sel = '0;
        unique case (head.part_sel)
            2'd0: byte_sel = head.data[7:0];
            2'd1: byte_sel = head.data[15:8];
            2'd2: byte_sel = head.data[23:16];
            2'd3: byte_sel = head.data[31:24];
            default: byte_sel = '0;
        endcase

        // Half-word select uses part_sel[1] only.
        half_sel = head.part_sel[1]
                 ? head.data[31:16]
                 : head.data[15:0];

        sext     = 1'b0;
        int_data = head.data;
        if (head.is_byte_op) begin
            sext     = ~head.is_unsigned_op & byte_sel[7];
            int_data = {{(data_width_p-8){sext}}, byte_sel};
        end else if (head.is_hex_op) begin
            sext     = ~head.is_unsigned_op & half_sel[15];
            int_data = {{(data_width_p-16){sext}}, half_sel};
        end
    end

    assign int_wb_reg_id_o   = int_wb_v_o   ? head.reg_id : '0;
    assign int_wb_data_o     = int_wb_v_o   ? int_data    : '0;
    assign float_wb_reg_id_o = float_wb_v_o ? head.reg_id : '0;
    assign float_wb_data_o   = float_wb_v_o ? head.data   : '0;

    assign count_o = count_q;
    assign empty_o = empty;

    yumi_when_empty_a: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(empty & (int_wb_yumi_i | float_wb_yumi_i))
    ) else $error("yumi asserted while buffer empty");

    both_yumi_a: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(int_wb_yumi_i & float_wb_yumi_i)
    ) else $error("int and float yumi asserted together");

endmodule

// File: tb/tb_vanilla_remote_load_wb.sv
// Scoreboard bench for vanilla_remote_load_wb.
// Accepted responses are queued with expected writebacks.
`timescale 1ns/1ps
module tb_vanilla_remote_load_wb;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        resp_v_i;
    logic [42:0] resp_i;
    logic        resp_ready_o;
    logic        int_wb_v_o;
    logic [4:0]  int_wb_reg_id_o;
    logic [31:0] int_wb_data_o;
    logic        int_wb_yumi_i;
    logic        float_wb_v_o;
    logic [4:0]  float_wb_reg_id_o;
    logic [31:0] float_wb_data_o;
    logic        float_wb_yumi_i;
    logic [1:0]  count_o;
    logic        empty_o;

    vanilla_remote_load_wb #(
        .els_p(2), .reg_id_width_p(5), .data_width_p(32)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .resp_v_i(resp_v_i), .resp_i(resp_i),
        .resp_ready_o(resp_ready_o),
        .int_wb_v_o(int_wb_v_o),
        .int_wb_reg_id_o(int_wb_reg_id_o),
        .int_wb_data_o(int_wb_data_o),
        .int_wb_yumi_i(int_wb_yumi_i),
        .float_wb_v_o(float_wb_v_o),
        .float_wb_reg_id_o(float_wb_reg_id_o),
        .float_wb_data_o(float_wb_data_o),
        .float_wb_yumi_i(float_wb_yumi_i),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fp;
        logic [4:0]  rid;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   pops    = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [42:0] mk(
        input logic fp, input logic [4:0] rid,
        input logic uns, input logic byt,
        input logic hex, input logic [1:0] ps,
        input logic [31:0] d);
        return {fp, rid, uns, byt, hex, ps, d};
    endfunction

    function automatic exp_t model(input logic [42:0] r);
        exp_t        e;
        logic [31:0] d;
        logic [7:0]  b;
        logic [15:0] h;
        d      = r[31:0];
        e.fp   = r[42];
        e.rid  = r[41:37];
        b      = 8'(d >> (8 * r[33:32]));
        h      = r[33] ? d[31:16] : d[15:0];
        e.data = d;
        if (!e.fp && r[35])
            e.data = r[36] ? {24'h0, b} : {{24{b[7]}}, b};
        else if (!e.fp && r[34])
            e.data = r[36] ? {16'h0, h} : {{16{h[15]}}, h};
        return e;
    endfunction

    // Monitor: push on accepted enqueue, pop/compare on dequeue.
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i) begin
            if (resp_v_i && resp_ready_o)
                sb.push_back(model(resp_i));
            if ((int_wb_v_o && int_wb_yumi_i) ||
                (float_wb_v_o && float_wb_yumi_i)) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_port", float_wb_v_o, e.fp);
                    if (e.fp) begin
                        chk("fp_rid", float_wb_reg_id_o, e.rid);
                        chk("fp_data", float_wb_data_o, e.data);
                    end else begin
                        chk("int_rid", int_wb_reg_id_o, e.rid);
                        chk("int_data", int_wb_data_o, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic t_align(input string tag,
                           input logic [42:0] r,
                           input logic [31:0] exp);
        resp_v_i = 1'b1;
        resp_i   = r;
        @(negedge clk_i);
        chk({tag, "_nobypass"}, int_wb_v_o | float_wb_v_o, 0);
        tick();
        resp_v_i      = 1'b0;
        int_wb_yumi_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_v"}, int_wb_v_o, 1);
        chk(tag, int_wb_data_o, exp);
        tick();
        int_wb_yumi_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && !empty_o; i++) begin
            int_wb_yumi_i   = int_wb_v_o;
            float_wb_yumi_i = float_wb_v_o;
            tick();
        end
        int_wb_yumi_i   = 1'b0;
        float_wb_yumi_i = 1'b0;
        chk("drain_empty", empty_o, 1);
    endtask

    initial begin
        int p0;
        reset_i         = 1'b1;
        resp_v_i        = 1'b0;
        resp_i          = '0;
        int_wb_yumi_i   = 1'b0;
        float_wb_yumi_i = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;

        @(negedge clk_i);
        chk("rst_ready", resp_ready_o, 1);
        chk("rst_int_v", int_wb_v_o, 0);
        chk("rst_fp_v", float_wb_v_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);

        // Enqueue during reset is dropped.
        tick();
        reset_i  = 1'b1;
        resp_v_i = 1'b1;
        resp_i   = mk(0, 5'd9, 0, 0, 0, 2'd0, 32'h1234_5678);
        tick();
        reset_i  = 1'b0;
        resp_v_i = 1'b0;
        @(negedge clk_i);
        chk("rst_enq_count", count_o, 0);
        chk("rst_enq_empty", empty_o, 1);
        tick();

        t_align("b_ps2_s",
            mk(0, 5'd1, 0, 1, 0, 2'd2, 32'h80FF_7F01), 32'hFFFF_FFFF);
        t_align("b_ps3_u",
            mk(0, 5'd2, 1, 1, 0, 2'd3, 32'h80FF_7F01), 32'h0000_0080);
        t_align("b_ps1_s",
            mk(0, 5'd3, 0, 1, 0, 2'd1, 32'h80FF_7F01), 32'h0000_007F);
        t_align("h_ps2_s",
            mk(0, 5'd4, 0, 0, 1, 2'd2, 32'h8001_7FFE), 32'hFFFF_8001);
        t_align("h_ps0_u",
            mk(0, 5'd5, 1, 0, 1, 2'd0, 32'h8001_7FFE), 32'h0000_7FFE);
        t_align("h_ps1_u",
            mk(0, 5'd6, 1, 0, 1, 2'd1, 32'h8001_7FFE), 32'h0000_7FFE);
        t_align("byte_pri",
            mk(0, 5'd7, 0, 1, 1, 2'd0, 32'h8001_7FFE), 32'hFFFF_FFFE);
        t_align("word",
            mk(0, 5'd8, 1, 0, 0, 2'd3, 32'hDEAD_BEEF), 32'hDEAD_BEEF);

        // FP response: raw data, int yumi ignored.
        resp_v_i = 1'b1;
        resp_i   = mk(1, 5'd7, 0, 1, 0, 2'd1, 32'h3F80_0000);
        tick();
        resp_v_i = 1'b0;
        @(negedge clk_i);
        chk("fp_v", float_wb_v_o, 1);
        chk("fp_rid7", float_wb_reg_id_o, 7);
        chk("fp_raw", float_wb_data_o, 32'h3F80_0000);
        chk("fp_int_v", int_wb_v_o, 0);
        chk("fp_int_rid0", int_wb_reg_id_o, 0);
        chk("fp_int_data0", int_wb_data_o, 0);
        tick();
        int_wb_yumi_i = 1'b1;
        tick();
        int_wb_yumi_i = 1'b0;
        @(negedge clk_i);
        chk("fp_ign_count", count_o, 1);
        chk("fp_ign_v", float_wb_v_o, 1);
        tick();
        drain();

        // Full / backpressure.
        resp_v_i = 1'b1;
        resp_i   = mk(0, 5'd3, 0, 0, 0, 2'd0, 32'hAAAA_0003);
        tick();
        resp_i   = mk(1, 5'd4, 0, 0, 0, 2'd0, 32'hBBBB_0004);
        tick();
        resp_i   = mk(0, 5'd5, 1, 1, 0, 2'd1, 32'hCCCC_C5C5);
        @(negedge clk_i);
        chk("full_count", count_o, 2);
        chk("full_ready", resp_ready_o, 0);
        tick();
        @(negedge clk_i);
        chk("full_hold_cnt", count_o, 2);
        chk("full_hold_rdy", resp_ready_o, 0);
        tick();
        int_wb_yumi_i = 1'b1;
        tick();
        int_wb_yumi_i = 1'b0;
        @(negedge clk_i);
        chk("deq_count", count_o, 1);
        chk("deq_fp_v", float_wb_v_o, 1);
        chk("deq_fp_rid", float_wb_reg_id_o, 4);
        chk("deq_ready", resp_ready_o, 1);
        tick();
        resp_v_i = 1'b0;
        @(negedge clk_i);
        chk("third_enq", count_o, 2);
        tick();
        drain();

        // Streaming enqueue+dequeue at count 1, wraps pointers.
        resp_v_i = 1'b1;
        resp_i   = mk(0, 5'd1, 0, 0, 0, 2'd0, 32'h100);
        tick();
        p0 = pops;
        for (int i = 2; i <= 8; i++) begin
            resp_i        = mk(0, 5'(i), 0, 0, 0, 2'd0, 32'h100 * i);
            int_wb_yumi_i = 1'b1;
            tick();
            chk("stream_cnt", count_o, 1);
            chk("stream_rate", pops - p0, i - 1);
        end
        resp_v_i = 1'b0;
        tick();
        int_wb_yumi_i = 1'b0;
        chk("stream_end_cnt", count_o, 0);
        chk("stream_pops", pops - p0, 8);

        repeat (2) tick();
        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/vanilla_remote_load_wb.md
Name: vanilla_remote_load_wb

Overview:
- Receives remote load responses (remote_load_resp_s) returned from the manycore network to a vanilla core.
- Buffers them in a small FIFO and aligns and extends byte/half-word data.
- Presents each response as a writeback request to either the integer or the FP register file write port.
- The core pipeline owns those ports. It grants the buffered response a port by pulsing yumi in a cycle where the local WB stage is not writing.

Parameters:
- els_p, 2, FIFO depth in responses (power of 2, >=2)
- reg_id_width_p, 5, width of reg_id (= bsg_manycore_reg_id_width_gp)
- data_width_p, 32, response and register data width (fixed to 32)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- resp_v_i  in  1  response valid from network endpoint
- resp_i  in  reg_id_width_p+38  packed remote_load_resp_s {float_wb, reg_id, is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0], data[31:0]}
- resp_ready_o  out  1  FIFO can accept; transfer when resp_v_i & resp_ready_o
- int_wb_v_o  out  1  head entry targets integer RF
- int_wb_reg_id_o  out  reg_id_width_p  destination integer register
- int_wb_data_o  out  32  aligned, extended load data
- int_wb_yumi_i  in  1  core accepts int writeback this cycle
- float_wb_v_o  out  1  head entry targets FP RF
- float_wb_reg_id_o  out  reg_id_width_p  destination FP register
- float_wb_data_o  out  32  raw word for FP RF
- float_wb_yumi_i  in  1  core accepts FP writeback this cycle
- count_o  out  $clog2(els_p+1)  occupied entries
- empty_o  out  1  no responses buffered (fence/drain support)

Behaviour:
- Reset (synchronous, reset_i=1 at posedge):
  - Read and write pointers, and count, cleared to 0; buffered entries discarded.
  - Outputs after reset: resp_ready_o=1, int_wb_v_o=0, float_wb_v_o=0, count_o=0, empty_o=1.
  - Reset asserted mid-operation drops all pending entries the same cycle. Any yumi in that cycle is ignored.
- Enqueue:
  - resp_ready_o = (count != els_p). It does not depend on same-cycle dequeue (no full-bypass).
  - Enqueue on resp_v_i & resp_ready_o. resp_i is stored unmodified at the write pointer. Pointers wrap modulo els_p.
- Head presentation (combinational from head entry, zero latency from storage):
  - int_wb_v_o = !empty & !head.float_wb.
  - float_wb_v_o = !empty & head.float_wb.
  - Exactly one of the two is high when non-empty.
  - Data and reg_id outputs for an inactive port drive 0.
- Integer alignment, by priority:
  - is_byte_op: b = data[8*part_sel +: 8]. Result is zero-extended if is_unsigned_op, else sign-extended from b[7].
  - else is_hex_op: h = data[16*part_sel[1] +: 16]. part_sel[0] is ignored. Result is zero/sign-extended from h[15] the same way.
  - else: full 32-bit data.
- FP port: float_wb_data_o = head.data unmodified. byte/hex/unsigned/part_sel are ignored when float_wb=1.
- Dequeue:
  - Occurs on (int_wb_v_o & int_wb_yumi_i) | (float_wb_v_o & float_wb_yumi_i).
  - A yumi on the inactive port is ignored.
  - A yumi while empty is illegal: flagged by a simulation assertion, with no state change.
  - Both yumis high in one cycle is illegal: assertion.
- Simultaneous enqueue and dequeue:
  - Count is unchanged and both pointers advance.
  - When count==els_p, enqueue is blocked even if dequeue happens (resp_ready_o=0).
  - When count==0, the incoming response is not visible on the wb outputs until the next cycle (no enqueue-to-output bypass). Minimum latency is 1 cycle.
- Ordering: strict FIFO; responses write back in arrival order regardless of target RF.
- count_o = number of occupied entries. empty_o = (count_o==0).
- No combinational path from any yumi input to resp_ready_o, and none from resp_v_i to any output.

Test Plan:
- Reset, then idle: check resp_ready_o=1, int_wb_v_o=0, float_wb_v_o=0, count_o=0, empty_o=1. Then enqueue with reset_i=1: entry dropped, count_o stays 0.
- Signed/unsigned byte:
  - data=32'h80FF7F01, is_byte_op=1, part_sel=2, signed → int_wb_data_o=32'hFFFFFFFF.
  - Same with part_sel=3, unsigned → 32'h00000080.
  - part_sel=1, signed → 32'h0000007F.
- Half-word: data=32'h8001_7FFE, is_hex_op=1, part_sel=2, signed → 32'hFFFF8001. part_sel=0, unsigned → 32'h00007FFE. part_sel=1 gives the same result as part_sel=0.
- FP response: float_wb=1, is_byte_op=1, reg_id=7, data=32'h3F800000 → float_wb_v_o=1, float_wb_reg_id_o=7, float_wb_data_o=32'h3F800000, int_wb_v_o=0. An int_wb_yumi_i pulse is ignored (count unchanged).
- Full/backpressure (els_p=2): enqueue int r3 then FP f4 with yumis low → count_o=2, resp_ready_o=0. Hold a third response valid: it is not accepted. Yumi int: next cycle count_o=1, float_wb_v_o=1 for f4, resp_ready_o=1, and the third response enqueues.
- Simultaneous enqueue/dequeue at count_o=1 over 8 consecutive cycles with reg_ids 1..8 → count_o stays 1, writebacks emerge in order 1..8 including pointer wrap, one per cycle.
